// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes, FSM states and
// a helper that classifies control codes as legal or not.
package alu_arbiter_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // True when the shared ALU implements this control code.
    function automatic logic ctrl_is_legal(input logic [3:0] code);
        logic legal;
        case (code)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side handshakes plus the shared ALU drive/return bus.
// The arbiter uses the slave view; requesters and the ALU sit on the master view.
interface alu_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_op1;
    logic [NUM_REQ*DATA_W-1:0] req_op2;
    logic [NUM_REQ*4-1:0]      req_ctrl;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_zero;
    logic                      rsp_err;
    logic [DATA_W-1:0]         alu_operand1;
    logic [DATA_W-1:0]         alu_operand2;
    logic [3:0]                alu_control;
    logic [DATA_W-1:0]         alu_out;
    logic                      alu_zero;

    modport slave (
        input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_out, alu_zero,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
               alu_operand1, alu_operand2, alu_control
    );

    modport master (
        output req_valid, req_op1, req_op2, req_ctrl, rsp_ready, alu_out, alu_zero,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err,
               alu_operand1, alu_operand2, alu_control
    );
endinterface

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: scans requesters starting just after the
// previous grant and returns the first valid one as one-hot plus its index.
module alu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // First valid requester in rotation order after last_grant wins.
    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates several requesters onto one external combinational ALU.
// One transaction in flight: IDLE picks and captures, ISSUE drives the ALU
// for a single cycle and registers its result, RESP presents the result to
// the owning requester until it is consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 2
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [DATA_W-1:0] op1_vec  [NUM_REQ];
    logic [DATA_W-1:0] op2_vec  [NUM_REQ];
    logic [3:0]        ctrl_vec [NUM_REQ];

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  last_grant_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic [DATA_W-1:0] op1_reg, op2_reg;
    logic [3:0]        ctrl_reg;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;
    logic              err_reg;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               accept;
    logic [NUM_REQ-1:0] ready_vec;
    logic [NUM_REQ-1:0] valid_vec;

    // Unpack the per-requester operand and control slices.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign op1_vec[gi]  = bus.req_op1[gi*DATA_W +: DATA_W];
            assign op2_vec[gi]  = bus.req_op2[gi*DATA_W +: DATA_W];
            assign ctrl_vec[gi] = bus.req_ctrl[gi*4 +: 4];
        end
    endgenerate

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid      (bus.req_valid),
        .last_grant (last_grant_reg),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; handshakes are masked while reset is low.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        ready_vec  = '0;
        valid_vec  = '0;
        case (state_reg)
            ST_IDLE: begin
                ready_vec = rst_n ? pick_grant : '0;
                if (|pick_grant) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                valid_vec[owner_reg] = rst_n;
                if (bus.rsp_ready[owner_reg]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture at the handshake and result capture at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            owner_reg      <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            ctrl_reg       <= '0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_reg <= pick_idx;
                owner_reg      <= pick_idx;
                op1_reg        <= op1_vec[pick_idx];
                op2_reg        <= op2_vec[pick_idx];
                ctrl_reg       <= ctrl_vec[pick_idx];
            end
            if (state_reg == ST_ISSUE) begin
                if (ctrl_is_legal(ctrl_reg)) begin
                    result_reg <= bus.alu_out;
                    zero_reg   <= bus.alu_zero;
                    err_reg    <= 1'b0;
                end else begin
                    result_reg <= '0;
                    zero_reg   <= 1'b1;
                    err_reg    <= 1'b1;
                end
            end
        end
    end

    // ALU drive comes straight from the capture registers, so it only moves
    // when a new request is accepted.
    assign bus.alu_operand1 = op1_reg;
    assign bus.alu_operand2 = op2_reg;
    assign bus.alu_control  = ctrl_reg;

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = valid_vec;
    assign bus.rsp_data  = result_reg;
    assign bus.rsp_zero  = zero_reg;
    assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of arbitration and ALU math.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_model = NR - 1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.DATA_W(DW), .NUM_REQ(NR)) bus ();

    alu_arbiter #(.DATA_W(DW), .NUM_REQ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External ALU; unsupported codes return junk that must be ignored.
    always_comb begin
        bus.alu_out  = '0;
        bus.alu_zero = 1'b0;
        case (bus.alu_control)
            4'b0000: bus.alu_out = bus.alu_operand1 & bus.alu_operand2;
            4'b0001: bus.alu_out = bus.alu_operand1 | bus.alu_operand2;
            4'b0010: bus.alu_out = bus.alu_operand1 + bus.alu_operand2;
            4'b0110: bus.alu_out = bus.alu_operand1 - bus.alu_operand2;
            4'b0111: bus.alu_out = ($signed(bus.alu_operand1) < $signed(bus.alu_operand2)) ? 32'd1 : 32'd0;
            default: bus.alu_out = 32'hDEAD_BEEF;
        endcase
        bus.alu_zero = (bus.alu_out == '0);
    end

    // Expected response {err, zero, data} for one request.
    function automatic logic [DW+1:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] d;
        logic          e;
        e = 1'b0;
        d = '0;
        if (c == CTRL_AND)      d = a & b;
        else if (c == CTRL_OR)  d = a | b;
        else if (c == CTRL_ADD) d = a + b;
        else if (c == CTRL_SUB) d = a - b;
        else if (c == CTRL_SLT) d = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        else                    e = 1'b1;
        return {e, (d == '0), d};
    endfunction

    // Next winner: first valid requester after the previous grant, -1 if none.
    function automatic int model_pick(input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last_model + k) % NR]) return (last_model + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_op();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
        return DW'($urandom);
    endfunction

    function automatic logic [3:0] rand_ctrl();
        logic [3:0] legal [5];
        legal = '{CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT};
        if ($urandom_range(0, 4) != 0) return legal[$urandom_range(0, 4)];
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] c);
        bus.req_op1[i*DW +: DW] = a;
        bus.req_op2[i*DW +: DW] = b;
        bus.req_ctrl[i*4 +: 4]  = c;
    endtask

    // One full transaction from an IDLE sample point; stall cycles present
    // rsp_ready only on non-owner requesters.
    task automatic do_txn(input int stall, input string tag, output int acc_cyc, output int win);
        logic [DW+1:0] r;
        logic [DW-1:0] a, b;
        logic [3:0]    c;
        #1;
        acc_cyc = cyc;
        win     = model_pick(bus.req_valid);
        if (win < 0) begin
            chk($sformatf("%s_ready_none", tag), 64'(bus.req_ready), 64'd0);
            return;
        end
        a = bus.req_op1[win*DW +: DW];
        b = bus.req_op2[win*DW +: DW];
        c = bus.req_ctrl[win*4 +: 4];
        r = ref_alu(c, a, b);
        chk($sformatf("%s_ready", tag), 64'(bus.req_ready), 64'(onehot(win)));
        tick();
        last_model = win;
        chk($sformatf("%s_issue_ready", tag), 64'(bus.req_ready), 64'd0);
        chk($sformatf("%s_issue_valid", tag), 64'(bus.rsp_valid), 64'd0);
        chk($sformatf("%s_alu_op1", tag), 64'(bus.alu_operand1), 64'(a));
        chk($sformatf("%s_alu_ctrl", tag), 64'(bus.alu_control), 64'(c));
        tick();
        bus.rsp_ready = ~onehot(win);
        for (int s = 0; s < stall; s++) begin
            #1;
            chk($sformatf("%s_stall_valid", tag), 64'(bus.rsp_valid), 64'(onehot(win)));
            chk($sformatf("%s_stall_data", tag), 64'(bus.rsp_data), 64'(r[DW-1:0]));
            chk($sformatf("%s_stall_flags", tag), 64'({bus.rsp_err, bus.rsp_zero}), 64'(r[DW+1:DW]));
            chk($sformatf("%s_stall_ready", tag), 64'(bus.req_ready), 64'd0);
            tick();
        end
        chk($sformatf("%s_rsp_valid", tag), 64'(bus.rsp_valid), 64'(onehot(win)));
        chk($sformatf("%s_rsp_data", tag), 64'(bus.rsp_data), 64'(r[DW-1:0]));
        chk($sformatf("%s_rsp_flags", tag), 64'({bus.rsp_err, bus.rsp_zero}), 64'(r[DW+1:DW]));
        chk($sformatf("%s_alu_op2_hold", tag), 64'(bus.alu_operand2), 64'(b));
        bus.rsp_ready = '1;
        tick();
        chk($sformatf("%s_rsp_done", tag), 64'(bus.rsp_valid), 64'd0);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        int acc, prev, win, v;
        logic [DW-1:0] a;

        bus.req_valid = '1;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = '0;
        rst_n         = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_alu_op1", 64'(bus.alu_operand1), 64'd0);
        chk("rst_alu_op2", 64'(bus.alu_operand2), 64'd0);
        chk("rst_alu_ctrl", 64'(bus.alu_control), 64'd0);

        rst_n         = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("idle_none_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("idle_none_valid", 64'(bus.rsp_valid), 64'd0);

        // Single add from requester 0.
        set_req(0, 32'd5, 32'd3, CTRL_ADD);
        bus.req_valid = 2'b01;
        do_txn(0, "single", acc, win);
        chk("single_data8", 64'(bus.rsp_data), 64'd8);
        bus.req_valid = '0;

        // Contention straight after reset: grants alternate, 3 cycles apart.
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        last_model = NR - 1;
        set_req(0, 32'h10, 32'h01, CTRL_OR);
        set_req(1, 32'h0F, 32'h33, CTRL_AND);
        bus.req_valid = 2'b11;
        bus.rsp_ready = '1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            do_txn(0, "cont", acc, win);
            chk("cont_grant", 64'(win), 64'(k % 2));
            if (k > 0) chk("cont_spacing", 64'(acc - prev), 64'd3);
            prev = acc;
        end
        bus.req_valid = '0;

        // Backpressure on a zero result from requester 1.
        set_req(1, 32'd7, 32'd7, CTRL_SUB);
        bus.req_valid = 2'b10;
        do_txn(5, "bp", acc, win);
        chk("bp_owner", 64'(win), 64'd1);
        bus.req_valid = '0;

        // Unsupported control code.
        set_req(0, 32'd9, 32'd4, 4'b1111);
        bus.req_valid = 2'b01;
        do_txn(0, "illegal", acc, win);
        bus.req_valid = '0;

        // Requester 0 owns the result while only requester 1 signals ready.
        set_req(0, 32'd2, 32'd6, CTRL_SLT);
        bus.req_valid = 2'b01;
        do_txn(3, "wrong_owner", acc, win);
        bus.req_valid = '0;

        // Reset while the response is pending.
        set_req(0, 32'd1, 32'd1, CTRL_ADD);
        set_req(1, 32'd2, 32'd2, CTRL_ADD);
        bus.req_valid = 2'b11;
        bus.rsp_ready = '0;
        #1;
        win = model_pick(bus.req_valid);
        tick();
        tick();
        chk("rstresp_pending", 64'(bus.rsp_valid), 64'(onehot(win)));
        rst_n = 1'b0;
        tick();
        chk("rstresp_dropped", 64'(bus.rsp_valid), 64'd0);
        rst_n      = 1'b1;
        last_model = NR - 1;
        #1;
        chk("rstresp_r0_wins", 64'(bus.req_ready), 64'd1);
        do_txn(0, "post_rst", acc, win);
        chk("post_rst_owner", 64'(win), 64'd0);

        // Randomized traffic, including idle gaps and requesters withdrawing.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) begin
                a = rand_op();
                set_req(i, a, ($urandom_range(0, 3) == 0) ? a : rand_op(), rand_ctrl());
            end
            v = int'($urandom_range(0, 3));
            bus.req_valid = NR'(v);
            if (v == 0) begin
                #1;
                chk("rand_idle_ready", 64'(bus.req_ready), 64'd0);
                tick();
                chk("rand_idle_valid", 64'(bus.rsp_valid), 64'd0);
            end else begin
                do_txn(int'($urandom_range(0, 3)), "rand", acc, win);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter NUM_REQ, default 2, number of requesters; legal values 2..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester acceptance; at most one bit high.
REQ-007 req_op1, req_op2  input  NUM_REQ*DATA_W each  packed operands, requester i at slice i.
REQ-008 req_ctrl  input  NUM_REQ*4  packed ALU control codes.
REQ-009 rsp_valid  output  NUM_REQ  result available for requester i.
REQ-010 rsp_ready  input  NUM_REQ  requester i consumes result.
REQ-011 rsp_data  output  DATA_W  result, shared bus, valid when any rsp_valid bit high.
REQ-012 rsp_zero  output  1  zero flag of result.
REQ-013 rsp_err  output  1  illegal control code flag.
REQ-014 alu_operand1, alu_operand2  output  DATA_W each  drive to shared combinational ALU.
REQ-015 alu_control  output  4  drive to shared ALU.
REQ-016 alu_out  input  DATA_W; alu_zero  input  1  shared ALU results.

Function
REQ-017 States IDLE, ISSUE, RESP; one transaction outstanding at a time.
REQ-018 IDLE: round-robin pick among req_valid bits starting after last_grant; req_ready high only for the winner, combinationally from req_valid.
REQ-019 Handshake req_valid[i]&req_ready[i] in IDLE captures op1/op2/ctrl and owner i, updates last_grant=i, moves to ISSUE.
REQ-020 IDLE with no req_valid: stay IDLE, req_ready all low.
REQ-021 ISSUE (exactly one cycle): alu_* driven from captured registers; alu_out/alu_zero registered at cycle end; move to RESP.
REQ-022 Legal codes 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 set-on-less-than; any other code: rsp_err=1, rsp_data=0, rsp_zero=1, ALU result ignored.
REQ-023 RESP: rsp_valid[owner]=1, rsp_data/rsp_zero/rsp_err held stable until rsp_ready[owner]; then IDLE next cycle.
REQ-024 rsp_ready of non-owner requesters ignored.
REQ-025 Latency: accept cycle N -> rsp_valid high at cycle N+2; minimum spacing between accepts 3 cycles.
REQ-026 Outside ISSUE, alu_* outputs hold last captured values (no glitching toggles).
REQ-027 req_ready low in ISSUE and RESP regardless of req_valid.
REQ-028 A requester deasserting req_valid before handshake loses nothing; no state change.

Reset
REQ-029 rst_n low at a rising edge: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), captured registers 0.
REQ-030 Under reset: req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_* =0.
REQ-031 Reset during ISSUE or RESP discards the transaction; no rsp_valid produced.

Structure
REQ-032 Shared package holds ALU control code constants (AND, OR, ADD, SUB, SLT) and state enum.
REQ-033 One sub-module alu_rr_pick: combinational round-robin winner from req_valid and last_grant, one-hot output.
REQ-034 ALU itself external; not instantiated inside this block.

Verification
REQ-035 Single req: r0 op1=5, op2=3, ctrl=0010 accepted cycle N -> rsp_valid[0] at N+2, rsp_data=8, rsp_zero=0, rsp_err=0.
REQ-036 Contention: r0 and r1 valid continuously -> grants alternate 0,1,0,1 after reset; each accept 3 cycles apart with rsp_ready tied high.
REQ-037 Backpressure: r1 sub 7-7, rsp_ready[1] low 5 cycles -> rsp_valid[1], rsp_data=0, rsp_zero=1 held stable; req_ready all low throughout.
REQ-038 Illegal code ctrl=1111 from r0 -> rsp_err=1, rsp_data=0, rsp_zero=1 at N+2.
REQ-039 Reset asserted in RESP cycle -> next cycle rsp_valid=0, state IDLE, next contention grant goes to r0.
REQ-040 Wrong-owner rsp_ready: r0 owns result, rsp_ready[1]=1 only -> rsp_valid[0] stays high, no state change.
